// File: rtl/pipe_hazard_controller_pkg.sv
// Shared ISA constants and hazard-control types for the pipeline controller.
// Imported by the hazard controller top and the mul/div sequencer.
package pipe_hazard_controller_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic md_start;
    } hz_ctl_t;

    localparam hz_ctl_t HZ_NONE = '0;

    function automatic logic src_match(
        input logic     uses,
        input reg_idx_t src,
        input reg_idx_t dst
    );
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_controller_muldiv_sequencer.sv
// Busy/done sequencer for the multi-cycle multiply/divide unit.
// Counts the selected latency down and pulses done as HI/LO becomes valid.
module muldiv_sequencer
    import pipe_hazard_controller_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic isDiv,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = isDiv ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                // Saturating decrement; a zero count can only drop back to idle
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = MD_IDLE;
                    done_d  = (cnt_q == CNT_ONE);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == MD_BUSY);
    assign done = done_q;

endmodule

// File: rtl/pipe_hazard_controller.sv
// Stall/flush decisions for load-use, taken branches and HI/LO dependencies.
// Also launches the mul/div sequencer when its operands leave ID.
module pipe_hazard_controller
    import pipe_hazard_controller_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  reg_idx_t idRs,
    input  reg_idx_t idRt,
    input  logic     idUsesRs,
    input  logic     idUsesRt,
    input  logic     idIsMulDiv,
    input  logic     idIsDiv,
    input  logic     idReadsHiLo,
    input  logic     exValid,
    input  logic     exMemRead,
    input  reg_idx_t exRt,
    input  logic     exBranchTaken,
    output logic     pcStall,
    output logic     ifIdStall,
    output logic     ifIdFlush,
    output logic     idExFlush,
    output logic     mdStart,
    output logic     mdBusy,
    output logic     mdDone
);

    logic    load_use;
    logic    hilo_wait;
    logic    seq_busy;
    logic    seq_done;
    hz_ctl_t ctl;

    always_comb begin
        load_use = exValid && exMemRead && (exRt != ZERO_REG)
                   && (src_match(idUsesRs, idRs, exRt)
                       || src_match(idUsesRt, idRt, exRt));
    end

    assign hilo_wait = seq_busy && (idIsMulDiv || idReadsHiLo);

    always_comb begin
        ctl = HZ_NONE;
        if (reset) begin
            ctl = HZ_NONE;
        end else if (exBranchTaken) begin
            // ID holds a wrong-path instruction: squash it, ignore its hazards
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else if (load_use || hilo_wait) begin
            ctl.pc_stall    = 1'b1;
            ctl.if_id_stall = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else begin
            ctl.md_start = idIsMulDiv && !seq_busy;
        end
    end

    muldiv_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_seq (
        .clk   (clk),
        .reset (reset),
        .start (ctl.md_start),
        .isDiv (idIsDiv),
        .busy  (seq_busy),
        .done  (seq_done)
    );

    assign pcStall   = ctl.pc_stall;
    assign ifIdStall = ctl.if_id_stall;
    assign ifIdFlush = ctl.if_id_flush;
    assign idExFlush = ctl.id_ex_flush;
    assign mdStart   = ctl.md_start;
    assign mdBusy    = seq_busy;
    assign mdDone    = seq_done;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Scoreboard bench for pipe_hazard_controller: per-cycle expected outputs
// are queued as stimulus is driven and compared at the falling edge.
module tb_pipe_hazard_controller;

    localparam int MC = 4;
    localparam int DC = 32;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       md;
        logic       dv;
        logic       hl;
        logic       ev;
        logic       emr;
        logic [4:0] ert;
        logic       br;
        logic       rst;
    } in_t;

    // {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone}
    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_LU    = 7'b1101000;
    localparam logic [6:0] E_BR    = 7'b0011000;
    localparam logic [6:0] E_START = 7'b0000100;
    localparam logic [6:0] E_STB   = 7'b1101010;
    localparam logic [6:0] E_BUSY  = 7'b0000010;
    localparam logic [6:0] E_DONE  = 7'b0000001;
    localparam logic [6:0] E_STDN  = 7'b0000101;
    localparam logic [6:0] E_BRB   = 7'b0011010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] idRs, idRt, exRt;
    logic       idUsesRs, idUsesRt, idIsMulDiv, idIsDiv, idReadsHiLo;
    logic       exValid, exMemRead, exBranchTaken;
    logic       pcStall, ifIdStall, ifIdFlush, idExFlush;
    logic       mdStart, mdBusy, mdDone;

    int checks = 0;
    int fails  = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_controller #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .idRs          (idRs),
        .idRt          (idRt),
        .idUsesRs      (idUsesRs),
        .idUsesRt      (idUsesRt),
        .idIsMulDiv    (idIsMulDiv),
        .idIsDiv       (idIsDiv),
        .idReadsHiLo   (idReadsHiLo),
        .exValid       (exValid),
        .exMemRead     (exMemRead),
        .exRt          (exRt),
        .exBranchTaken (exBranchTaken),
        .pcStall       (pcStall),
        .ifIdStall     (ifIdStall),
        .ifIdFlush     (ifIdFlush),
        .idExFlush     (idExFlush),
        .mdStart       (mdStart),
        .mdBusy        (mdBusy),
        .mdDone        (mdDone)
    );

    function automatic in_t mk(
        input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt,
        input logic md, input logic dv, input logic hl,
        input logic ev, input logic emr, input logic [4:0] ert,
        input logic br, input logic rst = 1'b0
    );
        in_t s;
        s = '{rs, rt, urs, urt, md, dv, hl, ev, emr, ert, br, rst};
        return s;
    endfunction

    function automatic in_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic in_t mult_i();
        return mk(4, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic in_t div_i();
        return mk(4, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    endfunction

    function automatic in_t mfhi_i();
        return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction

    task automatic apply(input in_t s);
        reset         = s.rst;
        idRs          = s.rs;
        idRt          = s.rt;
        idUsesRs      = s.urs;
        idUsesRt      = s.urt;
        idIsMulDiv    = s.md;
        idIsDiv       = s.dv;
        idReadsHiLo   = s.hl;
        exValid       = s.ev;
        exMemRead     = s.emr;
        exRt          = s.ert;
        exBranchTaken = s.br;
    endtask

    task automatic test_reset();
        in_t        s[$];
        logic [6:0] e[$];
        logic [6:0] got, want;
        s.push_back(mk(8, 9, 1, 1, 1, 0, 1, 1, 1, 8, 0, 1)); e.push_back(E_NONE);
        s.push_back(mk(8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1)); e.push_back(E_NONE);
        s.push_back(nop());                                  e.push_back(E_NONE);
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(e[k]);
            @(negedge clk);
            got  = {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset cyc%0d got %b want %b", k, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        in_t        s[$];
        logic [6:0] e[$];
        logic [6:0] got, want;
        s.push_back(mk(8, 9, 1, 1, 0, 0, 0, 1, 1, 8, 0)); e.push_back(E_LU);
        s.push_back(mk(8, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_NONE);
        s.push_back(mk(3, 8, 1, 0, 0, 0, 0, 1, 1, 8, 0)); e.push_back(E_NONE);
        s.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0)); e.push_back(E_NONE);
        s.push_back(mk(8, 8, 1, 1, 0, 0, 0, 1, 0, 8, 0)); e.push_back(E_NONE);
        s.push_back(mk(4, 8, 1, 1, 0, 0, 0, 1, 1, 8, 0)); e.push_back(E_LU);
        s.push_back(mk(8, 0, 1, 1, 0, 0, 0, 0, 1, 8, 0)); e.push_back(E_NONE);
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(e[k]);
            @(negedge clk);
            got  = {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL load_use cyc%0d got %b want %b", k, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        in_t        s[$];
        logic [6:0] e[$];
        logic [6:0] got, want;
        s.push_back(mk(8, 9, 1, 1, 0, 0, 0, 1, 1, 8, 1)); e.push_back(E_BR);
        s.push_back(mk(4, 5, 1, 1, 1, 0, 0, 0, 0, 0, 1)); e.push_back(E_BR);
        s.push_back(nop());                               e.push_back(E_NONE);
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(e[k]);
            @(negedge clk);
            got  = {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL branch cyc%0d got %b want %b", k, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mult_mfhi();
        in_t        s[$];
        logic [6:0] e[$];
        logic [6:0] got, want;
        s.push_back(mult_i()); e.push_back(E_START);
        for (int i = 0; i < MC; i++) begin
            s.push_back(mfhi_i()); e.push_back(E_STB);
        end
        s.push_back(mfhi_i()); e.push_back(E_DONE);
        s.push_back(nop());    e.push_back(E_NONE);
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(e[k]);
            @(negedge clk);
            got  = {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL mult_mfhi cyc%0d got %b want %b", k, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div();
        in_t        s[$];
        logic [6:0] e[$];
        logic [6:0] got, want;
        s.push_back(div_i()); e.push_back(E_START);
        for (int i = 1; i <= DC; i++) begin
            if (i == 10) begin
                s.push_back(mk(3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1)); e.push_back(E_BRB);
            end else if (i == 20) begin
                s.push_back(mk(8, 4, 1, 1, 0, 0, 0, 1, 1, 8, 0)); e.push_back(E_STB);
            end else begin
                s.push_back(mk(3, 4, 1, 1, 0, 0, 0, 1, 0, 7, 0)); e.push_back(E_BUSY);
            end
        end
        s.push_back(nop()); e.push_back(E_DONE);
        s.push_back(nop()); e.push_back(E_NONE);
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(e[k]);
            @(negedge clk);
            got  = {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL div cyc%0d got %b want %b", k, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        in_t        s[$];
        logic [6:0] e[$];
        logic [6:0] got, want;
        s.push_back(mult_i()); e.push_back(E_START);
        for (int i = 0; i < MC; i++) begin
            s.push_back(mult_i()); e.push_back(E_STB);
        end
        s.push_back(mult_i()); e.push_back(E_STDN);
        for (int i = 0; i < MC; i++) begin
            s.push_back(nop()); e.push_back(E_BUSY);
        end
        s.push_back(nop()); e.push_back(E_DONE);
        s.push_back(nop()); e.push_back(E_NONE);
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(e[k]);
            @(negedge clk);
            got  = {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL back_to_back cyc%0d got %b want %b", k, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_op();
        in_t        s[$];
        logic [6:0] e[$];
        logic [6:0] got, want;
        s.push_back(mult_i()); e.push_back(E_START);
        s.push_back(mfhi_i()); e.push_back(E_STB);
        s.push_back(mfhi_i()); e.push_back(E_STB);
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1)); e.push_back(E_NONE);
        s.push_back(mk(8, 9, 1, 1, 1, 0, 1, 1, 1, 8, 0, 1)); e.push_back(E_NONE);
        for (int i = 0; i < 6; i++) begin
            s.push_back(nop()); e.push_back(E_NONE);
        end
        s.push_back(mfhi_i()); e.push_back(E_NONE);
        s.push_back(mult_i()); e.push_back(E_START);
        s.push_back(mfhi_i()); e.push_back(E_STB);
        foreach (s[k]) begin
            apply(s[k]);
            exp_q.push_back(e[k]);
            @(negedge clk);
            got  = {pcStall, ifIdStall, ifIdFlush, idExFlush, mdStart, mdBusy, mdDone};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset_mid_op cyc%0d got %b want %b", k, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mult_mfhi();
        test_div();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
